// File: rtl/cpu_defs_pkg.sv
// Shared ISA, ALU-code and FSM-state definitions for the multi-cycle control unit.
// Field positions assume the fixed 16-bit instruction format.
package cpu_defs;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_MUL  = 4'h3;
    localparam logic [3:0] OP_JZ   = 4'h4;
    localparam logic [3:0] OP_JMP  = 4'h5;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [3:0] ALU_NONE = 4'b0000;
    localparam logic [3:0] ALU_ADD  = 4'b1010;
    localparam logic [3:0] ALU_SUB  = 4'b1011;
    localparam logic [3:0] ALU_MUL  = 4'b1100;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_WB     = 3'd4;
    localparam logic [2:0] ST_HALT   = 3'd5;

    localparam int OPC_LSB = 12;
    localparam int RD_LSB  = 8;
    localparam int RA_LSB  = 4;
    localparam int RB_LSB  = 0;
    localparam int IMM_W   = 8;

    typedef struct packed {
        logic       is_alu;
        logic       is_jz;
        logic       is_jmp;
        logic       is_halt;
        logic       is_illegal;
        logic [3:0] alu_code;
    } decode_t;

endpackage

// File: rtl/alu_control_unit_instr_decode.sv
// Combinational instruction classifier: turns the latched IR into control
// class bits and the ALU code the execute phase should issue.
module instr_decode
    import cpu_defs::*;
(
    input  logic [15:0] ir,
    output decode_t     dec
);

    // Unknown opcodes fall through as NOP but are flagged illegal.
    always_comb begin
        dec = '0;
        case (ir[OPC_LSB +: 4])
            OP_NOP:  ;
            OP_ADD:  begin dec.is_alu = 1'b1; dec.alu_code = ALU_ADD; end
            OP_SUB:  begin dec.is_alu = 1'b1; dec.alu_code = ALU_SUB; end
            OP_MUL:  begin dec.is_alu = 1'b1; dec.alu_code = ALU_MUL; end
            OP_JZ:   dec.is_jz   = 1'b1;
            OP_JMP:  dec.is_jmp  = 1'b1;
            OP_HALT: dec.is_halt = 1'b1;
            default: dec.is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_control_unit.sv
// Multi-cycle fetch/decode/execute/writeback controller driving the ALU opcode
// and register-file ports, with a latched zero flag for conditional jumps.
module alu_control_unit
    import cpu_defs::*;
#(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               imem_req,
    input  logic [INSTR_W-1:0] instr,
    input  logic               instr_valid,
    output logic [PC_W-1:0]    pc,
    output logic [3:0]         rf_ra,
    output logic [3:0]         rf_rb,
    output logic [3:0]         rf_wa,
    output logic               rf_we,
    output logic [3:0]         alu_op,
    input  logic               alu_z,
    output logic               z_flag,
    output logic               busy,
    output logic               halted,
    output logic               illegal
);

    logic [2:0]         state;
    logic [INSTR_W-1:0] ir;
    decode_t            dec;
    logic [PC_W-1:0]    pc_inc;
    logic [PC_W-1:0]    imm;

    instr_decode u_decode (
        .ir  (ir[15:0]),
        .dec (dec)
    );

    assign pc_inc = pc + PC_W'(1);
    assign imm    = PC_W'(ir[IMM_W-1:0]);

    // IR resets to zero, so the register ports read 0 until the first fetch.
    assign imem_req = (state == ST_FETCH);
    assign rf_ra    = ir[RA_LSB +: 4];
    assign rf_rb    = ir[RB_LSB +: 4];
    assign rf_wa    = ir[RD_LSB +: 4];
    assign rf_we    = (state == ST_WB);
    assign alu_op   = (state == ST_EXEC || state == ST_WB) ? dec.alu_code : ALU_NONE;
    assign busy     = (state != ST_IDLE) && (state != ST_HALT);
    assign halted   = (state == ST_HALT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            pc      <= '0;
            ir      <= '0;
            z_flag  <= 1'b0;
            illegal <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        pc    <= '0;
                        state <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (instr_valid) begin
                        ir    <= instr;
                        state <= ST_DECODE;
                    end
                end
                // Non-ALU instructions retire here; ALU ones advance pc in WB.
                ST_DECODE: begin
                    if (dec.is_halt) begin
                        state <= ST_HALT;
                    end else if (dec.is_alu) begin
                        state <= ST_EXEC;
                    end else begin
                        state <= ST_FETCH;
                        if (dec.is_jmp || (dec.is_jz && z_flag)) begin
                            pc <= imm;
                        end else begin
                            pc <= pc_inc;
                        end
                        if (dec.is_illegal) begin
                            illegal <= 1'b1;
                        end
                    end
                end
                ST_EXEC: begin
                    z_flag <= alu_z;
                    state  <= ST_WB;
                end
                ST_WB: begin
                    pc    <= pc_inc;
                    state <= ST_FETCH;
                end
                ST_HALT: ;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_control_unit.sv
// Self-checking bench: directed program fragments plus a random instruction
// stream, compared against an instruction-level model of the control unit.
module tb_alu_control_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        imem_req;
    logic [15:0] instr;
    logic        instr_valid;
    logic [7:0]  pc;
    logic [3:0]  rf_ra, rf_rb, rf_wa;
    logic        rf_we;
    logic [3:0]  alu_op;
    logic        alu_z;
    logic        z_flag, busy, halted, illegal;

    int vectors    = 0;
    int miscompares = 0;

    // Architectural model state
    logic [7:0] m_pc;
    logic       m_z;
    logic       m_illegal;

    alu_control_unit #(.PC_W(8), .INSTR_W(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .imem_req    (imem_req),
        .instr       (instr),
        .instr_valid (instr_valid),
        .pc          (pc),
        .rf_ra       (rf_ra),
        .rf_rb       (rf_rb),
        .rf_wa       (rf_wa),
        .rf_we       (rf_we),
        .alu_op      (alu_op),
        .alu_z       (alu_z),
        .z_flag      (z_flag),
        .busy        (busy),
        .halted      (halted),
        .illegal     (illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [3:0] expected_alu_code(input logic [3:0] opc);
        case (opc)
            4'h1:    return 4'b1010;
            4'h2:    return 4'b1011;
            4'h3:    return 4'b1100;
            default: return 4'b0000;
        endcase
    endfunction

    // Inputs that must be ignored outside their sampling windows get junk.
    task automatic drive_noise();
        instr_valid = 1'($urandom);
        instr       = 16'($urandom);
        alu_z       = 1'($urandom);
        start       = 1'($urandom);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        check_output({tag, "_imem_req"}, imem_req, 0);
        check_output({tag, "_pc"},       pc,       0);
        check_output({tag, "_rf_ra"},    rf_ra,    0);
        check_output({tag, "_rf_rb"},    rf_rb,    0);
        check_output({tag, "_rf_wa"},    rf_wa,    0);
        check_output({tag, "_rf_we"},    rf_we,    0);
        check_output({tag, "_alu_op"},   alu_op,   0);
        check_output({tag, "_z_flag"},   z_flag,   0);
        check_output({tag, "_busy"},     busy,     0);
        check_output({tag, "_halted"},   halted,   0);
        check_output({tag, "_illegal"},  illegal,  0);
    endtask

    task automatic do_start();
        start = 1'b1;
        next_cycle();
        start = 1'b0;
        m_pc  = 8'h00;
        check_output("start_fetch", imem_req, 1);
    endtask

    // Executes one instruction from FETCH entry; returns at the next FETCH (or HALT).
    task automatic apply_stimulus(input logic [15:0] word, input int waits, input logic zval);
        logic [3:0] opc;
        logic [3:0] code;
        logic       z_in;
        opc  = word[15:12];
        code = expected_alu_code(opc);
        z_in = (opc == 4'h1) ? 1'b0 : zval;

        check_output("fetch_req",     imem_req, 1);
        check_output("fetch_pc",      pc,       m_pc);
        check_output("fetch_z_flag",  z_flag,   m_z);
        check_output("fetch_illegal", illegal,  m_illegal);
        check_output("fetch_busy",    busy,     1);

        for (int i = 0; i < waits; i++) begin
            instr_valid = 1'b0;
            instr       = 16'($urandom);
            alu_z       = 1'($urandom);
            start       = 1'($urandom);
            next_cycle();
            check_output("wait_req",   imem_req, 1);
            check_output("wait_pc",    pc,       m_pc);
            check_output("wait_rf_we", rf_we,    0);
        end

        instr       = word;
        instr_valid = 1'b1;
        alu_z       = 1'($urandom);
        start       = 1'($urandom);
        next_cycle();

        drive_noise();
        check_output("dec_req",    imem_req, 0);
        check_output("dec_rf_ra",  rf_ra,    word[7:4]);
        check_output("dec_rf_rb",  rf_rb,    word[3:0]);
        check_output("dec_alu_op", alu_op,   0);
        check_output("dec_rf_we",  rf_we,    0);

        if (code != 4'b0000) begin
            next_cycle();
            drive_noise();
            alu_z = z_in;
            check_output("exec_alu_op", alu_op, code);
            check_output("exec_rf_we",  rf_we,  0);
            next_cycle();
            drive_noise();
            check_output("wb_rf_we",  rf_we,  1);
            check_output("wb_rf_wa",  rf_wa,  word[11:8]);
            check_output("wb_alu_op", alu_op, code);
            m_z  = z_in;
            m_pc = 8'((int'(m_pc) + 1) % 256);
            next_cycle();
        end else if (opc == 4'hF) begin
            next_cycle();
            check_output("halt_halted", halted,   1);
            check_output("halt_busy",   busy,     0);
            check_output("halt_req",    imem_req, 0);
            check_output("halt_pc",     pc,       m_pc);
        end else begin
            case (opc)
                4'h4:    m_pc = m_z ? word[7:0] : 8'((int'(m_pc) + 1) % 256);
                4'h5:    m_pc = word[7:0];
                4'h0:    m_pc = 8'((int'(m_pc) + 1) % 256);
                default: begin
                    m_pc      = 8'((int'(m_pc) + 1) % 256);
                    m_illegal = 1'b1;
                end
            endcase
            next_cycle();
        end
    endtask

    initial begin
        logic [3:0]  opc;
        logic [15:0] word;
        int          sel;

        rst_n       = 1'b0;
        start       = 1'b0;
        instr       = 16'h0000;
        instr_valid = 1'b0;
        alu_z       = 1'b0;
        m_pc        = 8'h00;
        m_z         = 1'b0;
        m_illegal   = 1'b0;

        repeat (2) @(negedge clk);
        check_reset_values("rst");
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_values("idle");

        do_start();
        apply_stimulus(16'h1312, 0, 1'b0);
        apply_stimulus(16'h2111, 0, 1'b1);
        apply_stimulus(16'h4040, 0, 1'b0);
        apply_stimulus(16'h3123, 1, 1'b0);
        apply_stimulus(16'h4040, 0, 1'b0);
        apply_stimulus(16'h0000, 5, 1'b0);
        apply_stimulus(16'h7000, 0, 1'b0);
        apply_stimulus(16'h50FF, 2, 1'b0);
        apply_stimulus(16'h0000, 0, 1'b0);

        for (int n = 0; n < 250; n++) begin
            sel = $urandom_range(0, 9);
            case (sel)
                0:       opc = 4'h0;
                1, 7:    opc = 4'h1;
                2, 8:    opc = 4'h2;
                3, 9:    opc = 4'h3;
                4:       opc = 4'h4;
                5:       opc = 4'h5;
                default: opc = 4'($urandom_range(6, 14));
            endcase
            word = {opc, 12'($urandom)};
            apply_stimulus(word, $urandom_range(0, 3), 1'($urandom));
        end

        apply_stimulus(16'hF000, 0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive_noise();
            start = 1'b1;
            next_cycle();
            check_output("halt_hold",    halted,   1);
            check_output("halt_hold_pc", pc,       m_pc);
            check_output("halt_no_req",  imem_req, 0);
        end
        start = 1'b0;

        // Asynchronous reset in the middle of an ALU instruction.
        rst_n = 1'b0;
        next_cycle();
        rst_n     = 1'b1;
        m_z       = 1'b0;
        m_illegal = 1'b0;
        instr_valid = 1'b0;
        @(negedge clk);
        do_start();
        instr       = 16'h1312;
        instr_valid = 1'b1;
        next_cycle();
        instr_valid = 1'b0;
        next_cycle();
        check_output("pre_rst_exec_op", alu_op, 4'b1010);
        #1 rst_n = 1'b0;
        #1 check_reset_values("async");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            check_output("post_rst_rf_we", rf_we, 0);
            check_output("post_rst_busy",  busy,  0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
